// File: rtl/pm_rst_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding, stage indices, counter width.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Stage mask decode lives here so the FSM and any monitor agree on the release pattern.
package pm_rst_pkg;

    localparam int CNT_W    = 16;
    localparam int STG_IO   = 0;
    localparam int STG_CORE = 1;
    localparam int STG_DP   = 2;

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL0      = 3'd2,
        ST_REL1      = 3'd3,
        ST_REL2      = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Stages come out of reset io -> core -> datapath; every other state holds all three.
    function automatic logic [2:0] stage_mask(state_t s);
        logic [2:0] m;
        m = 3'b111;
        case (s)
            ST_REL1: m[STG_IO] = 1'b0;
            ST_REL2: begin
                m[STG_IO]   = 1'b0;
                m[STG_CORE] = 1'b0;
            end
            ST_DONE: m = 3'b000;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pm_rst_cnt.sv
// Saturating up-counter cleared on state entry; at_term flags the terminal count.
// Latency: at_term is combinational from the registered count. Backpressure: none, en gates counting.
// The count stops at term and never wraps, so long dwells cannot alias to a short one.
module pm_rst_cnt
    import pm_rst_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != term)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_term = (cnt == term);

endmodule

// File: rtl/pm_reset_seq.sv
// Staged reset sequencer: hold, wait for clock lock, release io/core/datapath; optional lock timeout (PM_RST_SEQ_TIMEOUT_EN).
// Latency: outputs registered from next state, rst_done 4*HOLD_CYCLES+1 cycles after reset release with lock held.
// Backpressure: none; lock loss or soft_rst_req restarts the sequence on the next edge.
module pm_reset_seq
    import pm_rst_pkg::*;
#(
    parameter int HOLD_CYCLES  = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic       dest_clk,
    input  logic       clk_rst_in,
    input  logic       lock_in,
    input  logic       soft_rst_req,
    output logic [2:0] stage_rst_out,
    output logic       rst_done,
    output logic       seq_busy,
    output logic       timeout_err
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
        LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_param
        $error("pm_reset_seq: HOLD_CYCLES/LOCK_TIMEOUT out of range 1..65535");
    end

    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);

    state_t state;
    state_t nxt;
    logic   restart;
    logic   hold_clr;
    logic   hold_end;

    always_comb begin
        nxt      = state;
        restart  = soft_rst_req ||
                   (!lock_in && (state != ST_ASSERT) && (state != ST_WAIT_LOCK));
        if (restart) begin
            nxt = ST_ASSERT;
        end else begin
            case (state)
                ST_ASSERT:    if (hold_end) nxt = ST_WAIT_LOCK;
                // A flagged timeout parks the FSM here until reset or a soft request.
                ST_WAIT_LOCK: if (lock_in && !timeout_err) nxt = ST_REL0;
                ST_REL0:      if (hold_end) nxt = ST_REL1;
                ST_REL1:      if (hold_end) nxt = ST_REL2;
                ST_REL2:      if (hold_end) nxt = ST_DONE;
                ST_DONE:      nxt = ST_DONE;
                default:      nxt = ST_ASSERT;
            endcase
        end
        hold_clr = restart || (nxt != state);
    end

    pm_rst_cnt u_hold_cnt (
        .clk     (dest_clk),
        .rst     (clk_rst_in),
        .clr     (hold_clr),
        .en      (1'b1),
        .term    (HOLD_TERM),
        .at_term (hold_end)
    );

    always_ff @(posedge dest_clk or posedge clk_rst_in) begin
        if (clk_rst_in) begin
            state         <= ST_ASSERT;
            stage_rst_out <= 3'b111;
            rst_done      <= 1'b0;
            seq_busy      <= 1'b1;
        end else begin
            state         <= nxt;
            stage_rst_out <= stage_mask(nxt);
            rst_done      <= (nxt == ST_DONE);
            seq_busy      <= (nxt != ST_DONE);
        end
    end

`ifdef PM_RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'(LOCK_TIMEOUT - 1);

    logic tmo_end;

    pm_rst_cnt u_tmo_cnt (
        .clk     (dest_clk),
        .rst     (clk_rst_in),
        .clr     (hold_clr),
        .en      (state == ST_WAIT_LOCK),
        .term    (TMO_TERM),
        .at_term (tmo_end)
    );

    always_ff @(posedge dest_clk or posedge clk_rst_in) begin
        if (clk_rst_in) begin
            timeout_err <= 1'b0;
        end else if (soft_rst_req) begin
            timeout_err <= 1'b0;
        end else if ((state == ST_WAIT_LOCK) && !lock_in && tmo_end) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/pm_reset_seq.md
PM_RESET_SEQ -- requirements
Module: pm_reset_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles spent in each hold state (ASSERT, REL0..REL2); legal range 1..65535.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024: WAIT_LOCK cycles before the timeout error is flagged; legal range 1..65535.
REQ-003 SHALL have port dest_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port clk_rst_in, input, 1: asynchronous, active-high reset, normally the synchronized output of the upstream reset synchronizer.
REQ-005 SHALL have port lock_in, input, 1: clock-source lock, already synchronous to dest_clk.
REQ-006 SHALL have port soft_rst_req, input, 1: single-cycle software request to re-run the sequence.
REQ-007 SHALL have port stage_rst_out, output, 3: active-high stage resets; bit0 io, bit1 core, bit2 datapath.
REQ-008 SHALL have port rst_done, output, 1: high only when all stages are released.
REQ-009 SHALL have port seq_busy, output, 1: high in every state except DONE.
REQ-010 SHALL have port timeout_err, output, 1: sticky lock-timeout flag.

Function
REQ-011 SHALL implement FSM states ASSERT, WAIT_LOCK, REL0, REL1, REL2, DONE.
REQ-012 ASSERT SHALL last exactly HOLD_CYCLES cycles, then go to WAIT_LOCK.
REQ-013 WAIT_LOCK SHALL go to REL0 on the first cycle lock_in=1, giving a minimum dwell of 1 cycle.
REQ-014 Each RELk SHALL last exactly HOLD_CYCLES cycles, then advance to the next state (REL2 -> DONE).
REQ-015 All outputs SHALL be registered and SHALL update on the same edge as the state register.
REQ-016 stage_rst_out[0] SHALL be 0 in REL1, REL2 and DONE; [1] SHALL be 0 in REL2 and DONE; [2] SHALL be 0 only in DONE; all bits SHALL be 1 otherwise.
REQ-017 Release order SHALL be io, then core, then datapath; assertion SHALL be simultaneous on all bits.
REQ-018 rst_done SHALL rise on the same edge as stage_rst_out[2] falls.
REQ-019 With lock_in held high, rst_done SHALL rise 4*HOLD_CYCLES+1 cycles after the first edge with clk_rst_in low.
REQ-020 lock_in=0 in REL0..DONE SHALL force ASSERT on the next edge with the hold counter cleared, so all stages reassert.
REQ-021 soft_rst_req=1 in any state SHALL force ASSERT on the next edge with the hold counter cleared.
REQ-022 When soft_rst_req and lock loss coincide, the block SHALL take the single transition to ASSERT.
REQ-023 The hold counter SHALL be 16 bits, load 0 on state entry, terminate at HOLD_CYCLES-1, and never wrap.

Reset
REQ-024 clk_rst_in high SHALL asynchronously force: state ASSERT, counters 0, stage_rst_out=3'b111, rst_done=0, seq_busy=1, timeout_err=0.
REQ-025 Release of clk_rst_in SHALL take effect at the first dest_clk edge after release, with no extra synchronizer stage.
REQ-026 Reset asserted mid-sequence SHALL immediately override any state.

Configuration
REQ-027 With macro PM_RST_SEQ_TIMEOUT_EN defined, a 16-bit WAIT_LOCK counter SHALL set timeout_err after LOCK_TIMEOUT consecutive WAIT_LOCK cycles.
REQ-028 With the macro defined, the FSM SHALL remain in WAIT_LOCK after timeout, and timeout_err SHALL clear only on reset or soft_rst_req.
REQ-029 Without the macro, no timeout counter SHALL exist and timeout_err SHALL be constant 0.

Structure
REQ-030 Package pm_rst_pkg SHALL hold the state encoding, the stage index constants (STG_IO=0, STG_CORE=1, STG_DP=2) and the counter width constant (16).
REQ-031 The clear-on-state-entry, terminal-count counter SHALL be a sub-module pm_rst_cnt, shared by the hold counter and the timeout counter.

Verification
REQ-032 Run with HOLD_CYCLES=4 and lock_in=1 throughout: release reset -> stage_rst_out goes 111 until cycle 9, then 110, 100, 000 at 4-cycle steps; rst_done=1 at cycle 17.
REQ-033 Hold lock_in=0 for 20 cycles after ASSERT: FSM stays in WAIT_LOCK with stage_rst_out=111; raise lock_in -> rst_done rises 13 cycles later.
REQ-034 Drop lock_in for 1 cycle in DONE: next edge gives stage_rst_out=111, rst_done=0, seq_busy=1; the full sequence then reruns.
REQ-035 Pulse soft_rst_req in REL1: returns to ASSERT, counter restarts, and bit0 reasserts on the next edge.
REQ-036 Assert clk_rst_in asynchronously mid-REL2: outputs reach reset values before the next dest_clk edge.
REQ-037 With PM_RST_SEQ_TIMEOUT_EN, LOCK_TIMEOUT=8 and lock_in=0: timeout_err=1 after 8 WAIT_LOCK cycles; soft_rst_req clears it; without the macro timeout_err stays 0.
